// File: rtl/boot_loader_ctrl_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: the loader side (consumes bytes, drives imem writes).
// slave:  the environment side (byte source and imem).
interface boot_loader_ctrl_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/boot_loader_ctrl.sv
// Boot sequencer for the RV32I core: keeps the core in reset, loads a
// length-prefixed little-endian word image into imem, then releases the core
// after a fixed hold-off.
// Optional feature macro: BOOT_CHECKSUM_EN adds a 4-byte LE trailer holding
// the 32-bit sum of all loaded words; a mismatch ends in the error state.
module boot_loader_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MAX_WORDS   = 64,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    boot_loader_ctrl_if.master    bus,
    output logic                  core_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_ld
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        LEN0 = 3'd0,
        LEN1 = 3'd1,
        DATA = 3'd2,
        HOLD = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
`ifdef BOOT_CHECKSUM_EN
        , CSUM = 3'd6
`endif
    } loadState_e;

    loadState_e        state;
    logic [7:0]        lenLo;
    logic [15:0]       wordsTarget;
    logic [1:0]        byteCnt;
    logic [23:0]       byteBuf;
    logic [HOLD_W-1:0] holdCnt;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       csumAcc;
`endif

    logic        xfer;
    logic [15:0] lenWord;
    logic [31:0] fullWord;
    logic        lastWord;

    // Handshake qualifier and byte-assembly views of the current input byte
    assign xfer     = bus.in_valid & bus.in_ready;
    assign lenWord  = {bus.in_data, lenLo};
    assign fullWord = {bus.in_data, byteBuf};
    assign lastWord = ((words_ld + 16'd1) == wordsTarget);

    // Load sequencer: state plus all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= LEN0;
            lenLo          <= 8'd0;
            wordsTarget    <= 16'd0;
            byteCnt        <= 2'd0;
            byteBuf        <= 24'd0;
            holdCnt        <= '0;
`ifdef BOOT_CHECKSUM_EN
            csumAcc        <= 32'd0;
`endif
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= 32'd0;
            core_rst       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            words_ld       <= 16'd0;
        end else begin
            bus.imem_we <= 1'b0;
            case (state)
                LEN0: begin
                    bus.in_ready <= 1'b1;
                    busy         <= 1'b1;
                    if (xfer) begin
                        lenLo <= bus.in_data;
                        state <= LEN1;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        wordsTarget <= lenWord;
                        if (lenWord == 16'd0) begin
                            state        <= HOLD;
                            holdCnt      <= '0;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                        end else if (32'(lenWord) > MAX_WORDS) begin
                            state        <= ERR;
                            err          <= 1'b1;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            state   <= DATA;
                            byteCnt <= 2'd0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        if (byteCnt == 2'd3) begin
                            byteCnt        <= 2'd0;
                            bus.imem_we    <= 1'b1;
                            bus.imem_wdata <= fullWord;
                            bus.imem_addr  <= BASE_ADDR + (32'(words_ld) << 2);
                            words_ld       <= words_ld + 16'd1;
`ifdef BOOT_CHECKSUM_EN
                            csumAcc        <= csumAcc + fullWord;
                            if (lastWord) begin
                                state <= CSUM;
                            end
`else
                            if (lastWord) begin
                                state        <= HOLD;
                                holdCnt      <= '0;
                                bus.in_ready <= 1'b0;
                                busy         <= 1'b0;
                            end
`endif
                        end else begin
                            byteCnt <= byteCnt + 2'd1;
                            byteBuf <= {bus.in_data, byteBuf[23:8]};
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        if (byteCnt == 2'd3) begin
                            byteCnt      <= 2'd0;
                            bus.in_ready <= 1'b0;
                            busy         <= 1'b0;
                            if (fullWord == csumAcc) begin
                                state   <= HOLD;
                                holdCnt <= '0;
                            end else begin
                                state <= ERR;
                                err   <= 1'b1;
                            end
                        end else begin
                            byteCnt <= byteCnt + 2'd1;
                            byteBuf <= {bus.in_data, byteBuf[23:8]};
                        end
                    end
                end
`endif
                HOLD: begin
                    if (holdCnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        state    <= RUN;
                        core_rst <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        holdCnt <= holdCnt + 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state <= ERR;
                    err   <= 1'b1;
                end
            endcase
        end
    end

endmodule
